// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: grants one requester at a time, issues a single
// memory strobe and returns a one-cycle response (grant T, strobe T+1, response T+2).
module dmem_arbiter #(
   parameter int ADDR_LIMIT   = 256,
   parameter int FIXED_PRIO   = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic        req0_write,
   input  logic        req1_write,
   input  logic [15:0] req0_addr,
   input  logic [15:0] req1_addr,
   input  logic [15:0] req0_wdata,
   input  logic [15:0] req1_wdata,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic        rsp1_valid,
   output logic [15:0] rsp0_rdata,
   output logic [15:0] rsp1_rdata,
   output logic        rsp0_err,
   output logic        rsp1_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on a rising edge where reqN_valid && reqN_ready;
   // ready is only offered in IDLE, to at most one port, and never while reset is low.
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic        port_q, port_d;
   logic        err_q, err_d;
   logic        last_grant_q, last_grant_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;

   logic        pick1;
   logic        gnt0, gnt1;
   logic        issue, done;
   logic [15:0] sel_addr;
   logic [15:0] rd_data;

   // pick1 only matters when both ports are requesting.
   always_comb begin
      pick1 = 1'b0;
      if (FIXED_PRIO != 0) begin
         pick1 = (starve_cnt_q == 4'(STARVE_LIMIT));
      end else begin
         pick1 = (last_grant_q == 1'b0);
      end
      gnt0 = reset && (state_q == IDLE) && req0_valid && !(req1_valid && pick1);
      gnt1 = reset && (state_q == IDLE) && req1_valid && !(req0_valid && !pick1);
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      port_d       = port_q;
      err_d        = err_q;
      last_grant_d = last_grant_q;
      starve_cnt_d = starve_cnt_q;
      sel_addr     = gnt1 ? req1_addr : req0_addr;

      case (state_q)
         IDLE: begin
            if (gnt0 || gnt1) begin
               state_d      = ISSUE;
               addr_d       = sel_addr;
               wdata_d      = gnt1 ? req1_wdata : req0_wdata;
               write_d      = gnt1 ? req1_write : req0_write;
               port_d       = gnt1;
               err_d        = ({1'b0, sel_addr} >= 17'(ADDR_LIMIT));
               last_grant_d = gnt1;
            end
            if (gnt1) begin
               starve_cnt_d = 4'd0;
            end else if (gnt0) begin
               if (!req1_valid) begin
                  starve_cnt_d = 4'd0;
               end else if (starve_cnt_q < 4'(STARVE_LIMIT)) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         ISSUE:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         port_q       <= 1'b0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
         starve_cnt_q <= 4'd0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         port_q       <= port_d;
         err_q        <= err_d;
         last_grant_q <= last_grant_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Outputs decode the registered state, so reset clears them without waiting for a clock.
   always_comb begin
      issue      = (state_q == ISSUE);
      done       = (state_q == DONE);
      req0_ready = gnt0;
      req1_ready = gnt1;
      mem_en     = issue && !err_q;
      mem_we     = issue && !err_q && write_q;
      mem_addr   = issue ? addr_q : 16'h0000;
      mem_wdata  = issue ? wdata_q : 16'h0000;
      rd_data    = (!write_q && !err_q) ? mem_rdata : 16'h0000;
      rsp0_valid = done && !port_q;
      rsp1_valid = done && port_q;
      rsp0_rdata = rsp0_valid ? rd_data : 16'h0000;
      rsp1_rdata = rsp1_valid ? rd_data : 16'h0000;
      rsp0_err   = rsp0_valid && err_q;
      rsp1_err   = rsp1_valid && err_q;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance with a memory model and
// a fixed-priority instance (STARVE_LIMIT=2) used for the starvation grant order.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // round-robin instance signals
   logic        req0_valid = 0, req1_valid = 0, req0_write = 0, req1_write = 0;
   logic [15:0] req0_addr = 0, req1_addr = 0, req0_wdata = 0, req1_wdata = 0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
   logic [15:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata;
   logic        mem_en, mem_we;
   logic [15:0] mem_rdata = 0;
   logic [1:0]  dbg_state;

   // fixed-priority instance signals
   logic        f_v0 = 0, f_v1 = 0;
   logic [15:0] f_zero = 0;
   logic        f_r0, f_r1, f_rv0, f_rv1, f_re0, f_re1, f_en, f_we;
   logic [15:0] f_rd0, f_rd1, f_ma, f_mw;
   logic [1:0]  f_dbg;

   logic [15:0] mem [0:255];
   logic [31:0] exp_q[$];

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_write(req0_write), .req1_write(req1_write),
      .req0_addr(req0_addr), .req1_addr(req1_addr),
      .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_rdata(rsp0_rdata), .rsp1_rdata(rsp1_rdata),
      .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .dbg_state(dbg_state)
   );

   dmem_arbiter #(.ADDR_LIMIT(256), .FIXED_PRIO(1), .STARVE_LIMIT(2)) dut_fx (
      .clk(clk), .reset(reset),
      .req0_valid(f_v0), .req1_valid(f_v1),
      .req0_write(1'b0), .req1_write(1'b0),
      .req0_addr(16'h0030), .req1_addr(16'h0031),
      .req0_wdata(16'h0000), .req1_wdata(16'h0000),
      .req0_ready(f_r0), .req1_ready(f_r1),
      .rsp0_valid(f_rv0), .rsp1_valid(f_rv1),
      .rsp0_rdata(f_rd0), .rsp1_rdata(f_rd1),
      .rsp0_err(f_re0), .rsp1_err(f_re1),
      .mem_en(f_en), .mem_we(f_we), .mem_addr(f_ma), .mem_wdata(f_mw),
      .mem_rdata(f_zero), .dbg_state(f_dbg)
   );

   // Memory model: registered read; a write returns garbage so a non-zeroed rdata shows up.
   always @(posedge clk) begin
      if (!reset) begin
         mem[16] <= 16'hBEEF;
      end else if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ~mem_wdata;
         end else begin
            mem_rdata <= mem[mem_addr[7:0]];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the arbiter idle; returns at the negedge after the response.
   task automatic access(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input logic exp_err, input logic exp_en);
      if (p == 0) begin
         req0_valid = 1; req0_write = w; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = 1; req1_write = w; req1_addr = a; req1_wdata = d;
      end
      #1;
      check_eq("grant_ready", {30'd0, req0_ready, req1_ready}, (p == 0) ? 32'd2 : 32'd1);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #1;
      check_eq("issue_state", {30'd0, dbg_state}, 32'd1);
      check_eq("issue_en_we", {30'd0, mem_en, mem_we}, {30'd0, exp_en, exp_en & w});
      if (exp_en) begin
         check_eq("issue_addr", {16'd0, mem_addr}, {16'd0, a});
         check_eq("issue_wdata", {16'd0, mem_wdata}, {16'd0, d});
      end
      check_eq("issue_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
      @(negedge clk);
      #1;
      check_eq("done_valid", {30'd0, rsp0_valid, rsp1_valid}, (p == 0) ? 32'd2 : 32'd1);
      check_eq("done_rdata", {16'd0, (p == 0) ? rsp0_rdata : rsp1_rdata}, {16'd0, exp_rd});
      check_eq("done_err", {30'd0, rsp0_err, rsp1_err}, (p == 0) ? {30'd0, exp_err, 1'b0} : {31'd0, exp_err});
      check_eq("done_mem_idle", {31'd0, mem_en}, 32'd0);
      @(negedge clk);
   endtask

   // Both ports held valid; grant ports compared against exp_q, spacing must be 3 cycles.
   task automatic contend(input logic fx, input int n);
      int ng;
      int prev;
      logic r0, r1;
      ng = 0;
      prev = 0;
      if (fx) begin
         f_v0 = 1; f_v1 = 1;
      end else begin
         req0_valid = 1; req1_valid = 1; req0_write = 0; req1_write = 0;
         req0_addr = 16'h0020; req1_addr = 16'h0021;
      end
      for (int c = 0; c < 40 && ng < n; c++) begin
         #1;
         r0 = fx ? f_r0 : req0_ready;
         r1 = fx ? f_r1 : req1_ready;
         if (r0 || r1) begin
            check_eq("cont_onehot", {31'd0, r0 & r1}, 32'd0);
            check_eq("cont_port", {31'd0, r1}, exp_q.pop_front());
            if (ng > 0) check_eq("cont_gap", c - prev, 32'd3);
            prev = c;
            ng++;
         end
         @(negedge clk);
      end
      check_eq("cont_count", ng, n);
      f_v0 = 0; f_v1 = 0; req0_valid = 0; req1_valid = 0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      // reset held low with requests pending: nothing may be offered or driven
      req0_valid = 1; req1_valid = 1;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_ctrl", {22'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                            rsp1_err, mem_en, mem_we, dbg_state}, 32'd0);
      check_eq("rst_data", {mem_addr, mem_wdata}, 32'd0);
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      reset = 1;

      // single read, granted on the first edge with reset high
      access(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);

      // range boundary: ADDR_LIMIT and far out of range are errors, ADDR_LIMIT-1 is legal
      access(0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0);
      access(0, 1'b1, 16'hFFFF, 16'h5555, 16'h0000, 1'b1, 1'b0);
      access(0, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b1);

      // port 1 write then read back
      access(1, 1'b1, 16'h00FF, 16'h1234, 16'h0000, 1'b0, 1'b1);
      access(1, 1'b0, 16'h00FF, 16'h0000, 16'h1234, 1'b0, 1'b1);

      // round-robin: last grant was port 1, so order 0,1,0,1
      exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
      contend(1'b0, 4);

      // fixed priority, STARVE_LIMIT=2
      exp_q = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
      contend(1'b1, 6);

      // reset pulsed during ISSUE of a port-0 access
      req0_valid = 1; req0_write = 0; req0_addr = 16'h0010;
      @(negedge clk);
      req0_valid = 0;
      #1;
      check_eq("mid_issue_en", {31'd0, mem_en}, 32'd1);
      reset = 0;
      #1;
      check_eq("mid_rst_ctrl", {22'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err,
                                rsp1_err, mem_en, mem_we, dbg_state}, 32'd0);
      check_eq("mid_rst_data", {mem_addr, mem_wdata}, 32'd0);
      @(negedge clk);
      reset = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("abort_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
         @(negedge clk);
      end
      req0_valid = 1; req1_valid = 1;
      #1;
      check_eq("post_rst_tie", {30'd0, req0_ready, req1_ready}, 32'd2);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_LIMIT, 256, number of valid data-memory words; legal addresses are 0..ADDR_LIMIT-1.
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 priority with starvation guard.
- STARVE_LIMIT, 4, consecutive port-0 grants after which a waiting port 1 is forced (range 1..15).

REQ-002 Ports SHALL be (port 0 = core control path, port 1 = debug/loader):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- req0_valid, req1_valid  input  1  access request.
- req0_write, req1_write  input  1  1 = write, 0 = read.
- req0_addr, req1_addr  input  16  word address.
- req0_wdata, req1_wdata  input  16  write data.
- req0_ready, req1_ready  output  1  request accepted this cycle.
- rsp0_valid, rsp1_valid  output  1  one-cycle completion pulse.
- rsp0_rdata, rsp1_rdata  output  16  read data, valid with rspN_valid.
- rsp0_err, rsp1_err  output  1  out-of-range address, valid with rspN_valid.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable, qualified by mem_en.
- mem_addr  output  16  memory address.
- mem_wdata  output  16  memory write data.
- mem_rdata  input  16  memory read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-003 The FSM SHALL have three states, IDLE, ISSUE and DONE, with IDLE->ISSUE on a grant, ISSUE->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-004 reqN_ready SHALL be combinational, SHALL be asserted only in IDLE, and SHALL be asserted for at most one port per cycle.
REQ-005 On a grant, addr, wdata, write, port id and range check SHALL be captured into registers.
REQ-006 A requester SHALL hold valid and its fields stable until ready; valid dropped before ready SHALL cause no access.
REQ-007 In ISSUE, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL come from the captured registers, unless the captured address is >= ADDR_LIMIT, in which case mem_en SHALL be 0.
REQ-008 In DONE, rspN_valid SHALL be 1 for the captured port only, with:
- rdata = mem_rdata for an in-range read;
- rdata = 0 for a write or an error;
- err = 1 only for an out-of-range access.
REQ-009 Latency SHALL be: grant cycle T, memory strobe T+1, response T+2, next grant possible T+3; sustained throughput is one access per 3 cycles.
REQ-010 Outside ISSUE, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0; outside DONE, all rsp outputs SHALL be 0.
REQ-011 In round-robin mode, a lone valid SHALL be granted, and on simultaneous valids the port not granted last (last_grant register) SHALL win.
REQ-012 In fixed mode, port 0 SHALL win ties, except when starve_cnt == STARVE_LIMIT, in which case port 1 SHALL win.
REQ-013 starve_cnt (4 bits) SHALL:
- increment when port 0 is granted while req1_valid = 1;
- clear when port 1 is granted, or when port 0 is granted with req1_valid = 0;
- saturate at STARVE_LIMIT.
REQ-014 An address equal to ADDR_LIMIT SHALL be an error; ADDR_LIMIT-1 SHALL be legal; addresses SHALL never wrap.

Reset
REQ-015 Reset assertion SHALL immediately force: state = IDLE, every output = 0, last_grant = 1 (port 0 wins the first tie), starve_cnt = 0, and captured registers = 0.
REQ-016 Reset asserted during ISSUE or DONE SHALL abort the access, producing no rspN_valid for it, including after deassertion.
REQ-017 The first grant after reset deassertion SHALL be possible on the first rising edge with reset high.

Verification
REQ-018 Single read: mem preloaded [0x0010] = 0xBEEF, req0 read 0x0010 -> ready0 at T, mem_en=1/mem_we=0/addr 0x0010 at T+1, rsp0_valid with rdata 0xBEEF and err 0 at T+2.
REQ-019 Write then read: req1 writes 0x1234 to 0x00FF, then reads 0x00FF -> rsp1 ack with rdata 0, then rdata 0x1234, err 0.
REQ-020 Round-robin contention: both ports hold valid for 4 accesses -> grant order 0,1,0,1, with grants 3 cycles apart.
REQ-021 Fixed-priority starvation: FIXED_PRIO=1, STARVE_LIMIT=2, both ports held valid -> grant order 0,0,1,0,0,1.
REQ-022 Range check: read 0x0100 with ADDR_LIMIT=256 -> mem_en stays 0, rsp_valid with err 1 and rdata 0; address 0x00FF -> err 0.
REQ-023 Reset mid-access: reset pulsed low during ISSUE -> all outputs 0 immediately, no rsp_valid afterwards, and a following tie grants port 0.
